// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// motor_cmd_sequencer: switch debounce/decode, duty slew and dead-time reversal
// Rev 1.0
// ============================================================================
module motor_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RAMP_CYCLES     = 100000,
    parameter int STEP            = 5,
    parameter int DEAD_CYCLES     = 500000
) (
    input  logic       W5,
    input  logic       U18,
    input  logic [7:0] sw,
    output logic [6:0] duty,
    output logic       K17,
    output logic       M18,
    output logic       busy,
    output logic       conflict
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [7:0]        STEP8     = 8'(STEP);
    localparam logic [6:0]        STEP7     = 7'(STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DECEL = 2'd2;
    localparam logic [1:0] S_BRAKE = 2'd3;

    logic [7:0]        r_sw_meta, r_sw_sync, r_cand, r_cmd;
    logic [DB_W-1:0]   r_db_cnt;
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [1:0]        r_state;
    logic [6:0]        r_duty;
    logic              r_in1, r_in2;

    logic       w_single, w_fwd, w_same_dir, w_ramp_act, w_step, w_reach0;
    logic [3:0] w_nib;
    logic [6:0] w_tgt, w_goal, w_duty_next;
    logic [7:0] w_up, w_floor;

    always_ff @(posedge W5) begin
        if (U18) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_cand    <= '0;
            r_cmd     <= '0;
            r_db_cnt  <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync != r_cand) begin
                r_cand   <= r_sw_sync;
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_cmd <= r_cand;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_single = (r_cmd != 8'd0) && ((r_cmd & (r_cmd - 8'd1)) == 8'd0);
    assign w_fwd    = |r_cmd[3:0];
    assign w_nib    = w_fwd ? r_cmd[3:0] : r_cmd[7:4];

    always_comb begin
        w_tgt = 7'd0;
        if (w_single) begin
            case (w_nib)
                4'b0001: w_tgt = 7'd100;
                4'b0010: w_tgt = 7'd75;
                4'b0100: w_tgt = 7'd50;
                4'b1000: w_tgt = 7'd25;
                default: w_tgt = 7'd0;
            endcase
        end
    end

    // Opposite-direction or stop targets slew toward zero before the bridge is touched.
    assign w_same_dir = w_single && (w_fwd == r_in1);
    assign w_goal     = ((r_state == S_RUN) && w_same_dir) ? w_tgt : 7'd0;
    assign w_ramp_act = (r_duty != w_tgt) || (r_state == S_DECEL);
    assign w_step     = w_ramp_act && (r_ramp_cnt == RAMP_LAST);

    always_comb begin
        w_up        = {1'b0, r_duty} + STEP8;
        w_floor     = {1'b0, w_goal} + STEP8;
        w_duty_next = w_goal;
        if (r_duty < w_goal) begin
            if (w_up < {1'b0, w_goal}) w_duty_next = w_up[6:0];
        end else if ({1'b0, r_duty} >= w_floor) begin
            w_duty_next = r_duty - STEP7;
        end
    end

    assign w_reach0 = (r_duty == 7'd0) || (w_step && (w_duty_next == 7'd0));

    always_ff @(posedge W5) begin
        if (U18) begin
            r_state    <= S_IDLE;
            r_duty     <= '0;
            r_in1      <= 1'b0;
            r_in2      <= 1'b0;
            r_ramp_cnt <= '0;
            r_dead_cnt <= '0;
        end else begin
            if (!w_ramp_act || w_step) r_ramp_cnt <= '0;
            else                       r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_duty <= '0;
                    if (w_single) begin
                        r_state <= S_RUN;
                        r_in1   <= w_fwd;
                        r_in2   <= !w_fwd;
                    end
                end
                S_RUN: begin
                    if (!w_single) begin
                        if (w_reach0) begin
                            r_state <= S_IDLE;
                            r_duty  <= '0;
                            r_in1   <= 1'b0;
                            r_in2   <= 1'b0;
                        end else if (w_step) begin
                            r_duty <= w_duty_next;
                        end
                    end else if (!w_same_dir) begin
                        r_state <= S_DECEL;
                        if (w_step) r_duty <= w_duty_next;
                    end else if (w_step) begin
                        r_duty <= w_duty_next;
                    end
                end
                S_DECEL: begin
                    // A command back to the present direction cancels the reversal.
                    if (w_same_dir) begin
                        r_state <= S_RUN;
                    end else if (w_reach0) begin
                        r_state    <= S_BRAKE;
                        r_duty     <= '0;
                        r_in1      <= 1'b0;
                        r_in2      <= 1'b0;
                        r_dead_cnt <= '0;
                    end else if (w_step) begin
                        r_duty <= w_duty_next;
                    end
                end
                S_BRAKE: begin
                    r_duty <= '0;
                    if (r_dead_cnt == DEAD_LAST) begin
                        r_dead_cnt <= '0;
                        if (w_single) begin
                            r_state <= S_RUN;
                            r_in1   <= w_fwd;
                            r_in2   <= !w_fwd;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_dead_cnt <= r_dead_cnt + DEAD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_duty  <= '0;
                    r_in1   <= 1'b0;
                    r_in2   <= 1'b0;
                end
            endcase
        end
    end

    assign duty     = r_duty;
    assign K17      = r_in1;
    assign M18      = r_in2;
    assign busy     = (r_duty != w_tgt) || (r_state == S_DECEL) || (r_state == S_BRAKE);
    assign conflict = (r_cmd != 8'd0) && !w_single;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_motor_cmd_sequencer: scoreboard bench for the motor command sequencer
// Rev 1.0
// ============================================================================
module tb_motor_cmd_sequencer;

    logic       W5  = 1'b0;
    logic       U18 = 1'b1;
    logic [7:0] sw  = 8'h01;
    logic [6:0] duty;
    logic       K17, M18, busy, conflict;

    motor_cmd_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .RAMP_CYCLES    (2),
        .STEP           (5),
        .DEAD_CYCLES    (8)
    ) dut (
        .W5      (W5),
        .U18     (U18),
        .sw      (sw),
        .duty    (duty),
        .K17     (K17),
        .M18     (M18),
        .busy    (busy),
        .conflict(conflict)
    );

    always #5 W5 = ~W5;

    int         n_total = 0;
    int         n_bad   = 0;
    int         n_extra = 0;
    int         cyc     = 0;
    int         t0, t1, t2;
    logic [8:0] exp_q[$];
    logic [8:0] prev_tup = '0;
    logic [8:0] tup;

    assign tup = {K17, M18, duty};

    always @(posedge W5) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic k, input logic m, input int d);
        mk = {k, m, d[6:0]};
    endfunction

    // Queue every intermediate {K17,M18,duty} value of a 5% slew, excluding the start.
    task automatic push_ramp(input logic k, input logic m, input int from, input int to);
        if (to > from) for (int v = from + 5; v <= to; v += 5) exp_q.push_back(mk(k, m, v));
        else           for (int v = from - 5; v >= to; v -= 5) exp_q.push_back(mk(k, m, v));
    endtask

    task automatic wait_tup(input string tag, input logic [8:0] t, input int budget, output int at);
        int i = 0;
        while (i < budget && tup !== t) begin
            @(negedge W5);
            i++;
        end
        at = cyc;
        chk_eq(tag, tup, t);
    endtask

    always @(negedge W5) begin
        chk_eq("excl", {31'd0, K17 & M18}, 0);
        if (tup !== prev_tup) begin
            if (exp_q.size() == 0) n_extra++;
            else                   chk_eq("sb", tup, exp_q.pop_front());
            prev_tup = tup;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) begin
            @(negedge W5);
            chk_eq("rst_out", {duty, K17, M18, busy, conflict}, 0);
        end
        U18 = 1'b0;
        t0  = cyc;
        exp_q.push_back(mk(1, 0, 0));
        push_ramp(1, 0, 0, 100);
        wait_tup("fwd_start", mk(1, 0, 0), 40, t1);
        chk_eq("fwd_start_lat", t1 - t0, 8);
        wait_tup("fwd_100", mk(1, 0, 100), 100, t1);
        chk_eq("fwd_ramp_lat", t1 - t0, 47);

        // Forward -> reverse
        sw = 8'h10;
        push_ramp(1, 0, 100, 5);
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(0, 1, 0));
        push_ramp(0, 1, 0, 100);
        wait_tup("rev_brake", mk(0, 0, 0), 100, t1);
        wait_tup("rev_dir", mk(0, 1, 0), 20, t2);
        chk_eq("dead_time", t2 - t1, 8);
        wait_tup("rev_100", mk(0, 1, 100), 100, t1);

        // Reverse -> forward
        sw = 8'h01;
        push_ramp(0, 1, 100, 5);
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(1, 0, 0));
        push_ramp(1, 0, 0, 100);
        wait_tup("fwd2_100", mk(1, 0, 100), 200, t1);

        // Abort a reversal at duty 50; 45/40/35 pass before the new command lands
        sw = 8'h10;
        push_ramp(1, 0, 100, 50);
        wait_tup("dec_50", mk(1, 0, 50), 100, t1);
        sw = 8'h02;
        push_ramp(1, 0, 50, 35);
        push_ramp(1, 0, 35, 75);
        wait_tup("abort_75", mk(1, 0, 75), 100, t1);
        repeat (10) @(negedge W5);
        chk_eq("abort_hold", tup, mk(1, 0, 75));
        chk_eq("abort_busy", busy, 0);

        // Conflict handling
        sw = 8'h04;
        push_ramp(1, 0, 75, 50);
        wait_tup("conf_pre50", mk(1, 0, 50), 100, t1);
        sw = 8'h05;
        push_ramp(1, 0, 50, 5);
        exp_q.push_back(mk(0, 0, 0));
        for (int i = 0; i < 20 && conflict !== 1'b1; i++) @(negedge W5);
        chk_eq("conflict_on", conflict, 1);
        wait_tup("conf_idle", mk(0, 0, 0), 100, t1);
        chk_eq("conf_busy", busy, 0);
        sw = 8'h04;
        exp_q.push_back(mk(1, 0, 0));
        push_ramp(1, 0, 0, 50);
        for (int i = 0; i < 20 && conflict !== 1'b0; i++) @(negedge W5);
        chk_eq("conflict_off", conflict, 0);
        wait_tup("conf_50", mk(1, 0, 50), 100, t1);

        // Stop, then debounce against a chattering sw0
        sw = 8'h00;
        push_ramp(1, 0, 50, 5);
        exp_q.push_back(mk(0, 0, 0));
        wait_tup("stop", mk(0, 0, 0), 100, t1);
        repeat (8) @(negedge W5);
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 8'h01 : 8'h00;
            repeat (3) begin
                @(negedge W5);
                chk_eq("db_quiet", busy, 0);
            end
        end
        sw = 8'h01;
        t0 = cyc;
        exp_q.push_back(mk(1, 0, 0));
        push_ramp(1, 0, 0, 100);
        // First sampling edge is t0+1; acceptance follows 6 cycles later.
        for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge W5);
        chk_eq("db_accept_lat", cyc - t0, 7);
        wait_tup("db_100", mk(1, 0, 100), 100, t1);

        // Reset in the middle of the dead time
        sw = 8'h10;
        push_ramp(1, 0, 100, 5);
        exp_q.push_back(mk(0, 0, 0));
        wait_tup("mb_brake", mk(0, 0, 0), 100, t1);
        repeat (3) @(negedge W5);
        chk_eq("mb_busy", busy, 1);
        U18 = 1'b1;
        @(negedge W5);
        chk_eq("mb_rst", {duty, K17, M18, busy, conflict}, 0);
        U18 = 1'b0;
        t0  = cyc;
        exp_q.push_back(mk(0, 1, 0));
        push_ramp(0, 1, 0, 100);
        wait_tup("mb_restart", mk(0, 1, 0), 40, t1);
        chk_eq("mb_restart_lat", t1 - t0, 8);
        wait_tup("mb_100", mk(0, 1, 100), 100, t1);

        repeat (5) @(negedge W5);
        chk_eq("sb_extra", n_extra, 0);
        chk_eq("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Sits between the Basys 3 switches (sw0–sw7) and the Motor-A PWM generator / L298 direction pins.
- Debounces the switch bank and decodes it into a target direction and duty.
- Slews the duty command toward the target and never reverses the bridge under load: it ramps to 0, holds both bridge inputs low for a dead time, then flips direction and ramps up.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the switch vector must stay unchanged before it is accepted (10 ms at 100 MHz).
- RAMP_CYCLES, 100000: cycles between duty steps.
- STEP, 5: duty change per step, in percent.
- DEAD_CYCLES, 500000: cycles with K17=M18=0 between direction changes.

Ports:
- W5, input, 1: 100 MHz clock. One clock domain only.
- U18, input, 1: reset. Synchronous, active-high (btnC).
- sw, input, 8: raw switch levels. Asynchronous; pass through a 2-flop synchroniser.
- duty, output, 7: duty command to the PWM block, range 0..100 (percent of a 100-count period).
- K17, output, 1: L298 IN1. High means forward.
- M18, output, 1: L298 IN2. High means reverse.
- busy, output, 1: high while duty≠target, or while in DECEL or BRAKE.
- conflict, output, 1: high while the debounced command has more than one switch set.

Behaviour:
- Reset (U18 high at a W5 edge): duty=0, K17=0, M18=0, busy=0, conflict=0. State=IDLE. Debounce counter and ramp counter=0. Accepted command=all-zero. Reset mid-ramp or mid-brake takes effect on that edge; no ramp-down.
- Debounce: synchronised vector compared to a candidate register.
  - On a mismatch: load the candidate and clear the counter.
  - Otherwise, when the counter reaches DEBOUNCE_CYCLES-1, copy the candidate into the accepted command.
  - Accepted command changes DEBOUNCE_CYCLES+2 cycles after the last raw edge.
- Decode of the accepted command:
  - Exactly one bit set: sw0/1/2/3 → forward 100/75/50/25; sw4/5/6/7 → reverse 100/75/50/25.
  - Zero bits set: stop (target 0, no direction).
  - Two or more bits set: stop, and conflict=1.
- Ramp:
  - The ramp counter holds at 0 while duty==target and the state is not DECEL.
  - Otherwise it counts 0..RAMP_CYCLES-1; at terminal count it wraps and duty moves by STEP toward the step goal.
  - Clamp to the goal; no overshoot. Step goal = target in RUN, 0 in DECEL.
- Invariant: K17 and M18 are never both 1. A direction pin only changes while duty==0.
- FSM states: IDLE, RUN, DECEL, BRAKE.
  - IDLE: duty=0, K17=M18=0. On a non-stop target, go to RUN next cycle with the direction pin set and duty starting at 0.
  - RUN: ramp toward target.
    - Target becomes stop: ramp to 0, then go to IDLE with pins cleared on the same edge duty reaches 0.
    - Target is the opposite direction: go to DECEL.
    - Target is the same direction at a new value: re-ramp up or down in place.
  - DECEL: ramp to 0; pins unchanged.
    - When duty reaches 0: go to BRAKE and clear both pins.
    - If the target reverts to the current direction before 0 is reached: return to RUN (abort the reversal).
  - BRAKE: K17=M18=0 for exactly DEAD_CYCLES cycles. Target changes during BRAKE are tracked, not acted on. At expiry:
    - Non-stop target: RUN in the latest target direction.
    - Stop target: IDLE.
- Width rules:
  - duty is 7-bit unsigned.
  - Step arithmetic is done in 8 bits and saturates at the goal, with no underflow below 0.
  - Counters are sized by $clog2 of their parameter.

Test Plan (override DEBOUNCE_CYCLES=4, RAMP_CYCLES=2, STEP=5, DEAD_CYCLES=8):
- Reset:
  - Stimulus: assert U18 for 2 cycles with sw=8'h01.
  - Required: duty=0, K17=M18=0, busy=0 throughout reset. After release, duty reaches 100 in 20 steps (40 cycles after command accept), with K17=1 and M18=0.
- Debounce:
  - Stimulus: toggle sw0 every 3 cycles for 30 cycles, then hold 1.
  - Required: no command accepted during toggling. Accept occurs 6 cycles after the final edge.
- Reversal:
  - Stimulus: at duty=100 forward, set sw=8'h10.
  - Required: duty steps 100→0 with K17=1, then K17=M18=0 for exactly 8 cycles, then M18=1 and duty ramps 0→100. K17 and M18 are never high together.
- Abort reversal:
  - Stimulus: during DECEL at duty=50, set sw=8'h02.
  - Required: K17 stays 1, M18 stays 0, duty settles at 75 with no BRAKE entered.
- Conflict:
  - Stimulus: sw=8'h05 while running forward at 50.
  - Required: conflict=1 after debounce, duty ramps to 0, state goes to IDLE with pins 0.
  - Stimulus: then sw=8'h04.
  - Required: conflict=0, duty ramps to 50 forward.
- Reset mid-BRAKE:
  - Stimulus: pulse U18 for 1 cycle during BRAKE.
  - Required: all outputs 0 on the next edge, state IDLE.
